// File: rtl/fc_layer_param_pkg.sv
// fc_layer_param_pkg: state type, accumulator sizing and saturation helpers for fc_layer_param
package fc_layer_param_pkg;
    typedef enum logic {LOAD, COMPUTE} fc_state_t;

    function automatic int acc_w(input int t, input int m);
        return 2 * t + $clog2(m + 1);
    endfunction

    // Works on a wide signed value so one helper serves any T up to 63; callers truncate to T.
    function automatic logic signed [127:0] sat_t(input logic signed [127:0] acc, input int t);
        logic signed [127:0] hi;
        hi = (128'sd1 <<< (t - 1)) - 128'sd1;
        return acc > hi ? hi : acc < -hi - 128'sd1 ? -hi - 128'sd1 : acc;
    endfunction
endpackage

// File: rtl/fc_layer_param_rom.sv
// fc_layer_param_rom: row-major weight table and bias table, one registered read port per MAC lane
module fc_layer_param_rom #(
  parameter int    M     = 15,
  parameter int    N     = 13,
  parameter int    T     = 19,
  parameter int    P     = 1,
  parameter string WFILE = "fc_layer_param_w.mem",
  parameter string BFILE = "fc_layer_param_b.mem"
) (
  input  logic                         clk,
  input  logic [$clog2(N / P + 1)-1:0] grp,
  input  logic [$clog2(M)-1:0]         idx,
  output logic signed [T-1:0]          w [P],
  output logic signed [T-1:0]          b [P]
);
  localparam int WA = $clog2(N * M);
  localparam int BA = N > 1 ? $clog2(N) : 1;
  logic [T-1:0] wmem [N * M];
  logic [T-1:0] bmem [N];
  always_ff @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      w[p] <= wmem[WA'((int'(grp) * P + p) * M + int'(idx))];
      b[p] <= bmem[BA'(int'(grp) * P + p)];
    end
  end
endmodule

// File: rtl/fc_layer_param.sv
// fc_layer_param: streaming y = sat(W*x + b) with P MAC lanes; result draining overlaps the next load.
// Define FC_LAYER_RELU_EN to replace negative saturated results with zero.
module fc_layer_param
    import fc_layer_param_pkg::*;
#(
    parameter int    M     = 15,
    parameter int    N     = 13,
    parameter int    T     = 19,
    parameter int    P     = 1,
    parameter string WFILE = "fc_layer_param_w.mem",
    parameter string BFILE = "fc_layer_param_b.mem"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic [T-1:0] input_data,
    output logic         output_valid,
    input  logic         output_ready,
    output logic [T-1:0] output_data
);
    localparam int G  = N / P;
    localparam int AW = acc_w(T, M);
    localparam int PW = 2 * T;
    localparam int CW = $clog2(M + 2);
    localparam int NW = $clog2(N + 1);
    localparam int GW = $clog2(G + 1);
    localparam int XW = $clog2(M);
    localparam int OW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] M_C    = CW'(M);
    localparam logic [CW-1:0] LAST_C = CW'(M + 1);
    localparam logic [GW-1:0] LAST_G = GW'(G - 1);

    if (N % P != 0) begin : g_bad_p
        $error("fc_layer_param: N must be a multiple of P");
    end

    fc_state_t           state, state_n;
    logic [CW-1:0]       in_cnt, cyc;
    logic [NW-1:0]       wr_cnt, rd_cnt;
    logic [GW-1:0]       grp;
    logic [XW-1:0]       ridx;
    logic signed [T-1:0] xbuf [M];
    logic signed [T-1:0] obuf [N];
    logic signed [T-1:0] xr;
    logic signed [T-1:0] wr [P];
    logic signed [T-1:0] br [P];
    logic signed [PW-1:0] prod [P];
    logic signed [AW-1:0] acc [P];
    logic signed [T-1:0] res [P];
    logic                start, wb, fin;

    // rd_cnt==wr_cnt is 0==0 after reset and N==N once the previous vector is drained.
    assign start        = state == LOAD && in_cnt == M_C && rd_cnt == wr_cnt;
    assign wb           = state == COMPUTE && cyc == LAST_C;
    assign fin          = wb && grp == LAST_G;
    assign ridx         = cyc < M_C ? XW'(cyc) : '0;
    assign output_valid = rd_cnt < wr_cnt;
    assign output_data  = obuf[OW'(rd_cnt)];

    always_comb begin
        state_n     = state;
        input_ready = state == LOAD && in_cnt < M_C;
        if (start) state_n = COMPUTE;
        else if (fin) state_n = LOAD;
    end

    always_ff @(posedge clk) state <= reset ? LOAD : state_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            cyc    <= '0;
            grp    <= '0;
        end else begin
            if (input_valid && input_ready) in_cnt <= in_cnt + CW'(1);
            if (output_valid && output_ready) rd_cnt <= rd_cnt + NW'(1);
            if (start) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
                cyc    <= '0;
                grp    <= '0;
            end
            if (state == COMPUTE) cyc <= wb ? '0 : cyc + CW'(1);
            if (wb) begin
                wr_cnt <= wr_cnt + NW'(P);
                grp    <= fin ? '0 : grp + GW'(1);
            end
            if (fin) in_cnt <= '0;
        end
    end

    fc_layer_param_rom #(.M(M), .N(N), .T(T), .P(P), .WFILE(WFILE), .BFILE(BFILE)) u_rom (
        .clk (clk),
        .grp (grp),
        .idx (ridx),
        .w   (wr),
        .b   (br)
    );

    always_comb begin
        for (int p = 0; p < P; p++) begin
            prod[p] = PW'(xr) * PW'(wr[p]);
            res[p]  = T'(sat_t(128'(acc[p]), T));
`ifdef FC_LAYER_RELU_EN
            if (res[p][T-1]) res[p] = '0;
`endif
        end
    end

    // Element m arrives at cyc m+1; cyc 1 seeds the accumulator with the bias.
    always_ff @(posedge clk) begin
        if (input_valid && input_ready) xbuf[XW'(in_cnt)] <= input_data;
        xr <= xbuf[ridx];
        for (int p = 0; p < P; p++) begin
            acc[p] <= (cyc == CW'(1) ? AW'(br[p]) : acc[p]) + AW'(prod[p]);
            if (wb) obuf[OW'(int'(wr_cnt) + p)] <= res[p];
        end
    end
endmodule

// File: tb/tb_fc_layer_param.sv
// tb_fc_layer_param: randomized stream bench with a scoreboard against a plain-arithmetic model of y = sat(W*x + b).
module tb_fc_layer_param;
    localparam int M = 5;
    localparam int N = 6;
    localparam int T = 8;
    localparam int P = 2;
    localparam int MAXV = 2 ** (T - 1) - 1;
    localparam int MINV = -(2 ** (T - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         input_valid;
    logic         input_ready;
    logic [T-1:0] input_data;
    logic         output_valid;
    logic         output_ready;
    logic [T-1:0] output_data;

    int wt [N * M];
    int bs [N];
    int xv [M];
    int exp_q [$];
    int checks = 0;
    int passes = 0;
    bit hold_ready = 1'b0;

    fc_layer_param #(.M(M), .N(N), .T(T), .P(P), .WFILE(""), .BFILE("")) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, want);
    endtask

    function automatic int model_y(input int n);
        longint a = bs[n];
        for (int m = 0; m < M; m++) a += longint'(xv[m]) * wt[n * M + m];
        if (a > MAXV) a = MAXV;
        else if (a < MINV) a = MINV;
`ifdef FC_LAYER_RELU_EN
        if (a < 0) a = 0;
`endif
        return int'(a);
    endfunction

    task automatic send_vec();
        int m = 0;
        int guard = 0;
        for (int n = 0; n < N; n++) exp_q.push_back(model_y(n));
        while (m < M && guard < 2000) begin
            @(negedge clk);
            input_valid = $urandom_range(0, 3) != 0;
            input_data = input_ready ? T'(xv[m]) : T'($urandom);
            if (input_valid && input_ready) m++;
            guard++;
        end
        @(posedge clk);
        #1 input_valid = 1'b0;
        check("load_done", m, M);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            #1 k++;
        end
        check("drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_vec(input int mode);
        for (int m = 0; m < M; m++)
            xv[m] = mode == 0 ? $urandom_range(0, 6) - 3 :
                    mode == 1 ? $urandom_range(0, 255) - 128 :
                    ($urandom_range(0, 1) != 0 ? MAXV : MINV);
    endtask

    // Monitor: picks output_ready, then scores any transfer that will happen on the next edge.
    initial begin
        int e;
        output_ready = 1'b0;
        forever begin
            @(negedge clk);
            output_ready = hold_ready ? 1'b0 : $urandom_range(0, 3) != 0;
            if (!reset && output_valid && output_ready) begin
                check("output_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("y", int'($signed(output_data)), e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        input_valid = 1'b0;
        input_data = '0;
        for (int i = 0; i < N * M; i++) begin
            wt[i] = $urandom_range(0, 40) - 20;
            dut.u_rom.wmem[i] = T'(wt[i]);
        end
        for (int n = 0; n < N; n++) begin
            bs[n] = $urandom_range(0, 255) - 128;
            dut.u_rom.bmem[n] = T'(bs[n]);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_input_ready", int'(input_ready), 1);
        check("rst_output_valid", int'(output_valid), 0);

        rand_vec(0);
        send_vec();
        k = 0;
        while (!output_valid && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        check("first_valid_latency", k, M + 3);

        for (int m = 0; m < M; m++) xv[m] = 0;
        send_vec();
        for (int m = 0; m < M; m++) xv[m] = MAXV;
        send_vec();
        for (int m = 0; m < M; m++) xv[m] = MINV;
        send_vec();
        wait_drain();

        hold_ready = 1'b1;
        rand_vec(0);
        send_vec();
        rand_vec(1);
        send_vec();
        repeat (100) @(posedge clk);
        #1;
        check("stall_input_ready", int'(input_ready), 0);
        check("stall_output_valid", int'(output_valid), 1);
        hold_ready = 1'b0;
        wait_drain();

        rand_vec(1);
        send_vec();
        repeat (M + 6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        check("midrst_output_valid", int'(output_valid), 0);
        check("midrst_input_ready", int'(input_ready), 1);

        for (int v = 0; v < 40; v++) begin
            rand_vec($urandom_range(0, 2));
            send_vec();
        end
        wait_drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
